// File: rtl/mat_loader_complex_if.sv
// Stream-in / operand-out bundle between an element feeder, the loader and the
// complex matrix multiplier. The slave view is the loader's.
interface mat_loader_complex_if #(
    parameter int mat_num_row = 2
);
    localparam int NE = mat_num_row * mat_num_row;
    localparam int W  = 2 * 64 * NE;

    logic          s_valid;
    logic          s_ready;
    logic [63:0]   s_real;
    logic [63:0]   s_imag;
    logic          s_last;
    logic [W-1:0]  mat_a;
    logic [W-1:0]  mat_b;
    logic          mm_valid;
    logic          mm_start;
    logic          mm_done;
    logic          busy;
    logic          err;

    modport slave (
        input  s_valid, s_real, s_imag, s_last, mm_done,
        output s_ready, mat_a, mat_b, mm_valid, mm_start, busy, err
    );

    modport master (
        output s_valid, s_real, s_imag, s_last, mm_done,
        input  s_ready, mat_a, mat_b, mm_valid, mm_start, busy, err
    );
endinterface

// File: rtl/mat_loader_complex.sv
// Collects a row-major stream of complex doubles (A then B) into packed operand
// buses, issues valid/start to the multiplier and holds operands until done.
module mat_loader_complex #(
    parameter int mat_num_row = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mat_loader_complex_if.slave   bus
);
    localparam int NE = mat_num_row * mat_num_row;
    localparam int IW = $clog2(2 * NE) + 1;

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        ISSUE_V   = 3'd2,
        ISSUE_S   = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t              state, nxt;
    logic [IW-1:0]       idx, idx_nxt;

    logic [NE-1:0][63:0] a_re, a_im, b_re, b_im;

    logic s_ready_q, mm_valid_q, mm_start_q, busy_q, err_q;
    logic s_ready_d, mm_valid_d, mm_start_d, busy_d, err_d;

    logic xfer, at_a_end, at_end, frame_err, wr_ok;

    assign xfer      = bus.s_valid & s_ready_q;
    assign at_a_end  = (idx == IW'(NE - 1));
    assign at_end    = (idx == IW'(2 * NE - 1));
    // s_last must coincide exactly with the final B index; any mismatch drops the beat
    assign frame_err = xfer & (bus.s_last ^ at_end);
    assign wr_ok     = xfer & ~frame_err;

    // state register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LOAD_A;
            idx        <= '0;
            s_ready_q  <= 1'b0;
            mm_valid_q <= 1'b0;
            mm_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= nxt;
            idx        <= idx_nxt;
            s_ready_q  <= s_ready_d;
            mm_valid_q <= mm_valid_d;
            mm_start_q <= mm_start_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // next-state
    always_comb begin
        nxt     = state;
        idx_nxt = idx;
        case (state)
            LOAD_A: begin
                if (frame_err) begin
                    idx_nxt = '0;
                end else if (wr_ok) begin
                    idx_nxt = idx + 1'b1;
                    if (at_a_end) nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                if (frame_err) begin
                    nxt     = LOAD_A;
                    idx_nxt = '0;
                end else if (wr_ok) begin
                    if (at_end) nxt = ISSUE_V;
                    else        idx_nxt = idx + 1'b1;
                end
            end
            ISSUE_V: nxt = ISSUE_S;
            ISSUE_S: nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.mm_done) begin
                    nxt     = LOAD_A;
                    idx_nxt = '0;
                end
            end
            default: begin
                nxt     = LOAD_A;
                idx_nxt = '0;
            end
        endcase
    end

    // outputs decoded from the upcoming state so they register in step with it
    always_comb begin
        s_ready_d  = (nxt == LOAD_A) || (nxt == LOAD_B);
        mm_valid_d = (nxt == ISSUE_V) || (nxt == ISSUE_S);
        mm_start_d = (nxt == ISSUE_S);
        busy_d     = (nxt == ISSUE_V) || (nxt == ISSUE_S) || (nxt == WAIT_DONE);
        err_d      = frame_err;
    end

    // operand storage: each beat touches only its own real/imag slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_re <= '0;
            a_im <= '0;
            b_re <= '0;
            b_im <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < NE; k++) begin
                if (idx == IW'(k)) begin
                    a_re[k] <= bus.s_real;
                    a_im[k] <= bus.s_imag;
                end
                if (idx == IW'(NE + k)) begin
                    b_re[k] <= bus.s_real;
                    b_im[k] <= bus.s_imag;
                end
            end
        end
    end

    assign bus.mat_a    = {a_im, a_re};
    assign bus.mat_b    = {b_im, b_re};
    assign bus.s_ready  = s_ready_q;
    assign bus.mm_valid = mm_valid_q;
    assign bus.mm_start = mm_start_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
endmodule

// File: doc/mat_loader_complex.md
# mat_loader_complex

Upstream feeder for `mat_mult_complex`. It accepts a stream of double-precision complex elements, one per beat, in row-major order: all of A, then all of B. It assembles them into the packed `mat_a`/`mat_b` buses and issues the valid/start sequence to the multiplier. It then holds both operands stable until the multiplier reports `done`, and only after that accepts the next operand pair.

## Interface
Parameters:
- `mat_num_row`, default 2: matrix dimension N. NE = N*N elements per matrix. Legal range N ≥ 1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset. It is asserted asynchronously and released synchronously to `clk` by the system.
- `s_valid`  in  1: input element valid.
- `s_ready`  out  1: loader can accept an element.
- `s_real`  in  64: element real part, IEEE-754 double bits.
- `s_imag`  in  64: element imaginary part, IEEE-754 double bits.
- `s_last`  in  1: marks the final element of B (stream index 2*NE-1).
- `mat_a`  out  2*64*NE: packed A. Real part of element k=i*N+j is at `[64k +: 64]`; imaginary part is at `[64k + 64*NE +: 64]`.
- `mat_b`  out  2*64*NE: packed B, same layout as `mat_a`.
- `mm_valid`  out  1: operands valid, to multiplier `valid`.
- `mm_start`  out  1: start pulse, to multiplier `start`.
- `mm_done`  in  1: multiplier `done`.
- `busy`  out  1: high from ISSUE_V through the cycle `mm_done` is sampled.
- `err`  out  1: one-cycle pulse on a framing error.

## Operation
- Transfer occurs when `s_valid & s_ready` is high at a rising edge of `clk`.
- Element counter `idx` has width clog2(2*NE)+1. It counts 0..2*NE-1.
  - Beats with idx < NE write A element idx.
  - Beats with idx ≥ NE write B element idx−NE.
- Each beat writes only its own 64-bit real and imaginary slots. All other bits hold.
- FSM states and transitions:
  - LOAD_A: `s_ready`=1. On the transfer with idx=NE−1, go to LOAD_B.
  - LOAD_B: `s_ready`=1. On the transfer with idx=2*NE−1 and `s_last`=1, go to ISSUE_V.
  - ISSUE_V: lasts 1 cycle. `mm_valid`=1, `mm_start`=0. Then go to ISSUE_S.
  - ISSUE_S: lasts 1 cycle. `mm_valid`=1, `mm_start`=1. Then go to WAIT_DONE.
  - WAIT_DONE: `mm_valid`=0, `mm_start`=0, `s_ready`=0. When `mm_done` is sampled 1, clear idx and go to LOAD_A.
- Framing errors, in LOAD_A or LOAD_B:
  - A transfer with `s_last`=1 at any idx ≠ 2*NE−1 is an error.
  - A transfer at idx=2*NE−1 with `s_last`=0 is an error.
  - On an error: pulse `err` for 1 cycle, discard the beat, clear idx to 0, go to LOAD_A.
  - `mat_a`/`mat_b` contents are not cleared; they will be overwritten by the next load.
- `mm_done` is ignored outside WAIT_DONE. This covers a stale `done` still high from the previous run.
- `mat_a` and `mat_b` are constant from ISSUE_V entry until WAIT_DONE exit.
- No arithmetic is performed. Data passes bit-exact. NaN and denormal values pass through unchanged.

## Timing
Reset values (while `rst`=0):
- FSM in LOAD_A, idx=0.
- `mat_a`=0, `mat_b`=0.
- `mm_valid`=0, `mm_start`=0, `busy`=0, `err`=0.
- `s_ready`=0 during reset, then 1 from the first edge after release.

Latency and throughput:
- Registered outputs throughout. `s_ready` is decoded from state only.
- The last B beat accepted at edge t gives:
  - `mm_valid`=1 in cycles t+1 and t+2.
  - `mm_start`=1 in cycle t+2 only.
- `mm_done` sampled 1 at edge u gives `s_ready`=1 and `busy`=0 in cycle u+1.
- Throughput is 1 element/cycle when `s_valid` is held high. Minimum load time is 2*NE cycles.
- `s_valid` gaps stall the counter and never corrupt slots.
- Reset asserted mid-operation, in any state, returns immediately to the reset values. A partially loaded matrix is dropped and must be reloaded from element 0.

## Test plan
- N=2, stream A = {1+j2, 3+j4, 5+j6, 7+j8}, then B = {−1−j1, 0+j9, 2+j0, 4−j3}, `s_last` on beat 8:
  - `mat_a[0+:64]` = $realtobits(1.0) and `mat_a[256+:64]` = $realtobits(2.0).
  - `mat_b[192+:64]` = $realtobits(4.0).
  - `mm_valid` is 1 for 2 cycles and `mm_start` is 1 for the second of them.
  - `busy`=1.
- With `mm_done` held low for 50 cycles after issue, drive `s_valid`=1 throughout:
  - `s_ready` stays 0.
  - `mat_a`/`mat_b` are unchanged.
  - One cycle after `mm_done`=1, `s_ready`=1.
- Assert `s_last` on beat 3 of A (idx=2):
  - `err` pulses once.
  - The next beat is written to A element 0.
  - A full correct stream afterwards issues normally.
- Random `s_valid` gaps (≈50% duty) over two back-to-back operand pairs:
  - Packed buses match the reference packing exactly.
  - `mm_start` fires exactly once per pair.
- Drop `rst` to 0 after 5 beats:
  - All outputs are zero immediately.
  - After release, a full 8-beat load issues correctly.
- Hold `mm_done`=1 continuously from the previous run into ISSUE_V/ISSUE_S:
  - It is ignored during ISSUE_V/ISSUE_S.
  - The loader returns to LOAD_A only after WAIT_DONE samples `mm_done`=1.
